// File: rtl/spi_router_pkg.sv
// rtl/spi_router_pkg.sv - state encodings, header layout and counter widths for spi_msg_router
package spi_router_pkg;

    typedef enum logic [1:0] {
        P_DEST = 2'd0,
        P_LEN  = 2'd1,
        P_DATA = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_HDR0 = 2'd1,
        R_HDR1 = 2'd2,
        R_DATA = 2'd3
    } resp_state_t;

    localparam int HDR_IDX_POS = 0;
    localparam int HDR_LEN_POS = 1;
    localparam int ERR_CNT_W   = 8;

    // Header byte at a given position of an outbound packet: [idx][len]
    function automatic logic [7:0] hdr_byte(input int pos, input logic [7:0] idx, input logic [7:0] len);
        return (pos == HDR_IDX_POS) ? idx : len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requester after the last one served
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int idx;

    // Scan req starting just after last, wrapping, and stop at the first hit
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[IW'(idx)]) begin
                any       = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_msg_router.sv
// rtl/spi_msg_router.sv - host packet router between a byte link and multi-slave SPI FIFOs
module spi_msg_router
    import spi_router_pkg::*;
#(
    parameter int N_SLAVES  = 3,
    parameter int MAX_BURST = 64,
    parameter int TIMEOUT   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              m_din,
    output logic [N_SLAVES-1:0]     m_wrreq_bus,
    input  logic [8*N_SLAVES-1:0]   s_dout_bus,
    input  logic [8*N_SLAVES-1:0]   len_bus,
    input  logic [N_SLAVES-1:0]     have_msg_bus,
    output logic [N_SLAVES-1:0]     s_rdreq_bus,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // ---------------- inbound parser ----------------
    parse_state_t  p_state, p_next;
    logic [IW-1:0] dest_idx;
    logic          drop_q;
    logic [7:0]    remain_q;
    logic [TW-1:0] idle_q;
    logic          timeout_hit;
    logic          drop_end;
    logic          wr_fire;

    // Parser state register
    always_ff @(posedge clk) begin
        if (rst) p_state <= P_DEST;
        else     p_state <= p_next;
    end

    // Parser next state, write strobe and packet-discard events
    always_comb begin
        p_next      = p_state;
        drop_end    = 1'b0;
        wr_fire     = 1'b0;
        timeout_hit = (p_state != P_DEST) && !rx_valid && (idle_q == TW'(TIMEOUT - 1));
        case (p_state)
            P_DEST: begin
                if (rx_valid) p_next = P_LEN;
            end
            P_LEN: begin
                if (rx_valid) begin
                    p_next   = (rx_data == 8'd0) ? P_DEST : P_DATA;
                    drop_end = (rx_data == 8'd0) && drop_q;
                end else if (timeout_hit) begin
                    p_next = P_DEST;
                end
            end
            P_DATA: begin
                if (rx_valid) begin
                    wr_fire = !drop_q;
                    if (remain_q == 8'd1) begin
                        p_next   = P_DEST;
                        drop_end = drop_q;
                    end
                end else if (timeout_hit) begin
                    p_next = P_DEST;
                end
            end
            default: p_next = P_DEST;
        endcase
    end

    // Parser datapath: header latches, idle timer, registered FIFO write, error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_idx    <= '0;
            drop_q      <= 1'b0;
            remain_q    <= 8'd0;
            idle_q      <= '0;
            m_din       <= 8'd0;
            m_wrreq_bus <= '0;
            err_cnt     <= '0;
        end else begin
            if (p_state == P_DEST && rx_valid) begin
                dest_idx <= rx_data[IW-1:0];
                drop_q   <= (int'(rx_data) >= N_SLAVES);
            end
            if (p_state == P_LEN && rx_valid)  remain_q <= rx_data;
            if (p_state == P_DATA && rx_valid) remain_q <= remain_q - 8'd1;

            if (rx_valid || p_state == P_DEST || timeout_hit) idle_q <= '0;
            else                                              idle_q <= idle_q + 1'b1;

            m_wrreq_bus <= wr_fire ? (N_SLAVES'(1) << dest_idx) : '0;
            if (wr_fire) m_din <= rx_data;

            if ((timeout_hit || drop_end) && (err_cnt != {ERR_CNT_W{1'b1}}))
                err_cnt <= err_cnt + 1'b1;
        end
    end

    // ---------------- outbound response engine ----------------
    resp_state_t   r_state, r_next;
    logic [IW-1:0] sel_q;
    logic [IW-1:0] last_q;
    logic [7:0]    cnt_q;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic [7:0]    grant_len;
    logic [7:0]    snap_cnt;
    logic          sel_have;
    logic          r_pop;

    rr_arbiter #(.N(N_SLAVES)) u_arb (
        .req       (have_msg_bus),
        .last      (last_q),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Burst length snapshot; a zero fill level with data present means the counter wrapped
    always_comb begin
        grant_len = len_bus[8*grant_idx +: 8];
        if (grant_len == 8'd0 || int'(grant_len) > MAX_BURST) snap_cnt = 8'(MAX_BURST);
        else                                                   snap_cnt = grant_len;
    end

    // Response state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Response next state and the tx / pop outputs; nothing leaves while rst is high
    always_comb begin
        r_next      = r_state;
        tx_valid    = 1'b0;
        tx_data     = 8'd0;
        s_rdreq_bus = '0;
        r_pop       = 1'b0;
        sel_have    = have_msg_bus[sel_q];
        case (r_state)
            R_IDLE: begin
                if (grant_any) r_next = R_HDR0;
            end
            R_HDR0: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte(HDR_IDX_POS, 8'(sel_q), cnt_q);
                if (tx_ready) r_next = R_HDR1;
            end
            R_HDR1: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte(HDR_LEN_POS, 8'(sel_q), cnt_q);
                if (tx_ready) r_next = R_DATA;
            end
            R_DATA: begin
                tx_valid = sel_have;
                tx_data  = s_dout_bus[8*sel_q +: 8];
                if (sel_have && tx_ready) begin
                    r_pop       = 1'b1;
                    s_rdreq_bus = N_SLAVES'(1) << sel_q;
                    if (cnt_q == 8'd1) r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
        if (rst) begin
            tx_valid    = 1'b0;
            tx_data     = 8'd0;
            s_rdreq_bus = '0;
            r_pop       = 1'b0;
        end
    end

    // Response datapath: selected slave, remaining count and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            cnt_q  <= 8'd0;
            last_q <= IW'(N_SLAVES - 1);
        end else begin
            if (r_state == R_IDLE && grant_any) begin
                sel_q <= grant_idx;
                cnt_q <= snap_cnt;
            end
            if (r_pop) begin
                cnt_q <= cnt_q - 8'd1;
                if (cnt_q == 8'd1) last_q <= sel_q;
            end
        end
    end

endmodule
